// File: rtl/memory_responder_if.sv
// MFA/MFC handshake bundle between the control unit (master) and memory (slave).
interface memory_responder_if;
  logic        MFA;
  logic        READ_WRITE;
  logic        WORD_BYTE;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;

  modport master (output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
                  input  DataOut, MFC);
  modport slave  (input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
                  output DataOut, MFC);
endinterface

// File: rtl/memory_responder.sv
// Memory-side responder: latches a request on MFA, waits WAIT_CYCLES, performs a
// little-endian word/byte access on a byte-addressed RAM and raises MFC until MFA drops.
module memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  memory_responder_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic                  rd;
    logic                  word;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } req_t;

  state_t      state, state_nx;
  req_t        req;
  logic [3:0]  cnt;
  logic [31:0] dout_q;
  logic        fire;
  logic [7:0]  mem [DEPTH];

  // Address bits above the RAM size are deliberately dropped (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Address[31:ADDR_WIDTH];

  // Per-byte-lane addresses of the aligned word; lane 0 sits in bits [7:0].
  logic [ADDR_WIDTH-1:0] lane_addr [4];
  logic [3:0][7:0]       rd_lane;
  logic [31:0]           rd_val;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_addr[i] = {req.addr[ADDR_WIDTH-1:2], 2'(i)};
    assign rd_lane[i]   = mem[lane_addr[i]];
  end

  assign rd_val = req.word ? rd_lane : {24'h0, mem[req.addr]};
  assign fire   = (state == BUSY) && (cnt == 4'd0);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: capture on MFA, count down, hold DONE until MFA is released
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.MFA)  state_nx = BUSY;
      BUSY:    if (cnt == 0) state_nx = DONE;
      DONE:    if (!bus.MFA) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // Outputs: MFC is simply "in DONE"; read data is a held register
  always_comb begin
    bus.MFC     = (state == DONE);
    bus.DataOut = dout_q;
  end

  // Request latch, wait counter and read-data register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      req    <= '0;
      cnt    <= 4'd0;
      dout_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (bus.MFA) begin
          req.rd   <= bus.READ_WRITE;
          req.word <= bus.WORD_BYTE;
          req.addr <= bus.Address[ADDR_WIDTH-1:0];
          req.data <= bus.DataIn;
          cnt      <= 4'(WAIT_CYCLES);
        end
        BUSY: begin
          if (cnt != 4'd0)  cnt    <= cnt - 4'd1;
          else if (req.rd)  dout_q <= rd_val;
        end
        default: ;
      endcase
    end
  end

  // RAM write at the BUSY->DONE edge; a reset on that edge aborts it. No RAM reset.
  always_ff @(posedge Clk) begin
    if (!Reset && fire && !req.rd) begin
      if (req.word) begin
        for (int i = 0; i < 4; i++) mem[lane_addr[i]] <= req.data[8*i +: 8];
      end else begin
        mem[req.addr] <= req.data[7:0];
      end
    end
  end
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a transaction table plus hand-written
// handshake, reset and input-stability sequences.
module tb_memory_responder;
  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  memory_responder_if bus();

  memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rd;
    bit          word;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // expected DataOut for reads
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request and return just after the capture edge.
  task automatic start_req(input bit rd, input bit word, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(negedge Clk);
    bus.MFA        = 1'b1;
    bus.READ_WRITE = rd;
    bus.WORD_BYTE  = word;
    bus.Address    = addr;
    bus.DataIn     = wdata;
    @(posedge Clk); #1;
  endtask

  // Count edges from capture until MFC is seen (bounded).
  task automatic wait_mfc(output int lat);
    lat = 0;
    while (bus.MFC !== 1'b1 && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic end_req(input string name);
    @(negedge Clk);
    bus.MFA = 1'b0;
    @(posedge Clk); #1;
    check(name, 32'(bus.MFC), 32'h0);
  endtask

  initial begin
    int          lat;
    logic [31:0] last_rd;

    tbl[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1, 1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{0, 0, 32'h0000_0012, 32'hFFFF_FF5A, 32'h0};
    tbl[3]  = '{1, 1, 32'h0000_0010, 32'h0,         32'hDE5A_BEEF};
    tbl[4]  = '{1, 0, 32'h0000_0013, 32'h0,         32'h0000_00DE};
    tbl[5]  = '{1, 1, 32'h0000_0011, 32'h0,         32'hDE5A_BEEF};
    tbl[6]  = '{0, 1, 32'h0000_0100, 32'h1122_3344, 32'h0};
    tbl[7]  = '{1, 1, 32'h0000_0000, 32'h0,         32'h1122_3344};
    tbl[8]  = '{1, 0, 32'hFFFF_FF01, 32'h0,         32'h0000_0033};
    tbl[9]  = '{0, 1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0};
    tbl[10] = '{1, 1, 32'h0000_0022, 32'h0,         32'hCAFE_F00D};

    bus.MFA = 1'b1; bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b1;
    bus.Address = 32'h40; bus.DataIn = 32'h5555_5555;

    // Reset held two edges with MFA=1: nothing may be captured.
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_mfc", 32'(bus.MFC), 32'h0);
    check("reset_dout", bus.DataOut, 32'h0);
    @(negedge Clk);
    bus.MFA = 1'b0;
    Reset   = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("reset_no_capture", 32'(bus.MFC), 32'h0);
    last_rd = 32'h0;

    // Table of complete transactions
    for (int i = 0; i < 11; i++) begin
      start_req(tbl[i].rd, tbl[i].word, tbl[i].addr, tbl[i].wdata);
      wait_mfc(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      if (tbl[i].rd) last_rd = tbl[i].exp;
      check($sformatf("v%0d_dout", i), bus.DataOut, last_rd);
      end_req($sformatf("v%0d_mfc_drop", i));
    end

    // MFA held 5 cycles after MFC: MFC and DataOut hold; DataOut survives the exit.
    start_req(1, 1, 32'h10, 32'h0);
    wait_mfc(lat);
    check("hold_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      check($sformatf("hold_mfc%0d", k), 32'(bus.MFC), 32'h1);
    end
    check("hold_dout", bus.DataOut, 32'hDE5A_BEEF);
    end_req("hold_mfc_drop");
    check("hold_dout_after", bus.DataOut, 32'hDE5A_BEEF);

    // Inputs changed during BUSY are ignored (read of 0x0 turned into a "write" to 0x10).
    start_req(1, 1, 32'h0, 32'h0);
    bus.Address = 32'h10; bus.READ_WRITE = 1'b0; bus.DataIn = 32'h0BAD_0BAD; bus.WORD_BYTE = 1'b0;
    wait_mfc(lat);
    check("busy_chg_latency", 32'(lat), 32'd3);
    check("busy_chg_dout", bus.DataOut, 32'h1122_3344);
    end_req("busy_chg_mfc_drop");
    start_req(1, 1, 32'h10, 32'h0);
    wait_mfc(lat);
    check("busy_chg_no_write", bus.DataOut, 32'hDE5A_BEEF);
    end_req("busy_chg_mfc_drop2");

    // MFA dropped right after capture: access completes, MFC pulses one cycle.
    start_req(1, 0, 32'h13, 32'h0);
    bus.MFA = 1'b0;
    wait_mfc(lat);
    check("drop_latency", 32'(lat), 32'd3);
    check("drop_dout", bus.DataOut, 32'h0000_00DE);
    @(posedge Clk); #1;
    check("drop_pulse_end", 32'(bus.MFC), 32'h0);

    // Reset during BUSY of a write to 0x20: aborted, no MFC, RAM unchanged.
    start_req(0, 1, 32'h20, 32'h0102_0304);
    Reset = 1'b1;
    @(posedge Clk); #1;
    bus.MFA = 1'b0;
    Reset   = 1'b0;
    check("abort_dout_reset", bus.DataOut, 32'h0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_no_mfc%0d", k), 32'(bus.MFC), 32'h0);
      @(posedge Clk); #1;
    end
    start_req(1, 1, 32'h20, 32'h0);
    wait_mfc(lat);
    check("abort_latency", 32'(lat), 32'd3);
    check("abort_ram_kept", bus.DataOut, 32'hCAFE_F00D);
    end_req("abort_mfc_drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
